npu_layer_seq: RTL and testbench
================================

NPU_LAYER_SEQ -- requirements
Module: npu_layer_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  W  8  NPU array dimension; FC mode packs W px/word and W*W outputs/pass
  CLOG2T  2  tile-index width; max tiles per axis = 2**CLOG2T
  CNT_W  10  width of ifmap/ofmap counts and indices
  CLOG2L  3  layer-index width; descriptor table depth = 2**CLOG2L
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous active-high reset
  cfg_we  in  1  write descriptor
  cfg_addr  in  CLOG2L  descriptor slot
  cfg_mode  in  1  0=conv, 1=fc
  cfg_nb_tile  in  CLOG2T+1  tiles per axis (conv)
  cfg_nb_ifmaps  in  CNT_W  input maps (conv) / input features (fc)
  cfg_nb_ofmaps  in  CNT_W  output maps (conv) / output features (fc)
  nb_layers  in  CLOG2L+1  layers to run, sampled at start
  start  in  1  begin sequence
  busy  out  1  sequence in progress
  done  out  1  one-cycle completion pulse
  step_valid  out  1  step descriptor valid
  step_ready  in  1  consumer accepts step
  step_layer  out  CLOG2L  current layer
  step_mode  out  1  mode of current layer
  step_ofm  out  CNT_W  ofmap index (fc: output group)
  step_trow, step_tcol  out  CLOG2T each  tile row/col (0 in fc)
  step_ifm  out  CNT_W  ifmap index (fc: input word)
  step_first  out  1  first ifmap of accumulation (clear acc)
  step_last  out  1  last ifmap of accumulation (write out)
REQ-003 Reset SHALL be synchronous, active-high on rst; single clock clk.

Function
REQ-004 Descriptor table: 2**CLOG2L entries written on cfg_we at clk edge; cfg_we while busy=1 SHALL be ignored.
REQ-005 Loop bounds per layer: conv -> OFM=nb_ofmaps, T=nb_tile, IFM=nb_ifmaps; fc -> OFM=ceil(nb_ofmaps/(W*W)), T=1, IFM=ceil(nb_ifmaps/W).
REQ-006 Any zero count field SHALL be treated as 1; nb_tile > 2**CLOG2T SHALL saturate to 2**CLOG2T.
REQ-007 Loop order outer->inner: ofm, trow, tcol, ifm; steps per layer = OFM*T*T*IFM.
REQ-008 step_first=1 iff step_ifm=0; step_last=1 iff step_ifm=IFM-1 (both 1 when IFM=1).
REQ-009 FSM states IDLE, SETUP, RUN, DONE.
REQ-010 IDLE->SETUP on start with nb_layers>0; start with nb_layers=0 SHALL go IDLE->DONE; start while busy ignored.
REQ-011 SETUP (1 cycle): latch bounds of current layer, clear indices; ->RUN.
REQ-012 RUN: step_valid=1; indices advance only on step_valid&step_ready; outputs SHALL hold stable while step_ready=0.
REQ-013 Handshake of a layer's final step: -> SETUP with layer+1 if more layers, else -> DONE.
REQ-014 DONE (1 cycle): done=1, busy=0; ->IDLE.
REQ-015 busy=1 in SETUP and RUN only; step_valid=1 in RUN only.
REQ-016 Latency: start at edge t -> SETUP at t+1 -> first step_valid at t+2; one bubble cycle between layers; done asserted the cycle after final handshake.
REQ-017 nb_layers > 2**CLOG2L SHALL saturate to 2**CLOG2L.

Reset
REQ-018 On rst: state IDLE, busy=0, done=0, step_valid=0, all step_* index outputs 0, step_first=0, step_last=0; descriptor table contents undefined after reset and must be rewritten.
REQ-019 rst mid-run SHALL abort immediately with no done pulse.

Verification
REQ-020 Conv C1 {tile 4, ifm 1, ofm 6}, nb_layers=1, ready=1 -> 96 steps, first=last=1 every step, done at t+98.
REQ-021 C1 then C2 {tile 2, ifm 6, ofm 16} -> 96+384 steps, one bubble between, step_layer 0 then 1, last step (15,1,1,5) last=1.
REQ-022 FC {ifm 120, ofm 84}, W=8 -> OFM=2, IFM=15, 30 steps, trow=tcol=0, first at ifm 0, last at ifm 14.
REQ-023 Random step_ready backpressure on C2 -> identical step sequence to ready=1, outputs stable while stalled, exactly 384 handshakes.
REQ-024 Zero fields {tile 0, ifm 0, ofm 0} -> exactly 1 step; nb_layers=0 -> done at t+1 with no steps; rst at step 50 -> step_valid=0 and busy=0 next cycle, no done.

Source files
------------

// File: rtl/npu_layer_seq.sv
// -----------------------------------------------------------------------------
// npu_layer_seq
//
// Walks a small table of layer descriptors and emits one step descriptor per
// (ofmap, tile row, tile col, ifmap) combination for each layer, in that
// outer-to-inner order. Conv layers use their counts directly. FC layers
// fold the counts onto the W x W array:
//   - output groups = ceil(nb_ofmaps / (W*W))
//   - input words   = ceil(nb_ifmaps / W)
//   - a single 1x1 tile
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   cfg_*             descriptor write port (ignored while busy)
//   nb_layers         number of table entries to run, sampled with start
//   start             launches a sequence from IDLE
//   busy, done        status: busy in SETUP/RUN, done pulses for one cycle
//   step_*            step descriptor stream towards the array controller
//
// Step handshake: step_valid and every step_* field are registered and
// change only on a cycle where step_valid & step_ready were both high at the
// rising edge (or when a new layer is set up). While step_valid=1 and
// step_ready=0 all step outputs hold their values. The consumer may assert
// step_ready at any time; a step is transferred exactly on edges where both
// are high.
// -----------------------------------------------------------------------------
module npu_layer_seq #(
  parameter int W      = 8,
  parameter int CLOG2T = 2,
  parameter int CNT_W  = 10,
  parameter int CLOG2L = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CLOG2L-1:0] cfg_addr,
  input  logic              cfg_mode,
  input  logic [CLOG2T:0]   cfg_nb_tile,
  input  logic [CNT_W-1:0]  cfg_nb_ifmaps,
  input  logic [CNT_W-1:0]  cfg_nb_ofmaps,
  input  logic [CLOG2L:0]   nb_layers,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [CLOG2L-1:0] step_layer,
  output logic              step_mode,
  output logic [CNT_W-1:0]  step_ofm,
  output logic [CLOG2T-1:0] step_trow,
  output logic [CLOG2T-1:0] step_tcol,
  output logic [CNT_W-1:0]  step_ifm,
  output logic              step_first,
  output logic              step_last
);

  localparam int DEPTH = 2**CLOG2L;
  localparam int MAXT  = 2**CLOG2T;

  localparam logic [CLOG2T:0]  MAXT_V  = (CLOG2T+1)'(MAXT);
  localparam logic [CLOG2T:0]  ONE_T   = (CLOG2T+1)'(1);
  localparam logic [CLOG2L:0]  MAXL_V  = (CLOG2L+1)'(DEPTH);
  localparam logic [CLOG2L:0]  ONE_L   = (CLOG2L+1)'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  // FC divisors; W*W is assumed to fit in CNT_W bits.
  localparam logic [CNT_W-1:0] W_V     = CNT_W'(W);
  localparam logic [CNT_W-1:0] WW_V    = CNT_W'(W*W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Descriptor table. Not reset: software must rewrite it after reset.
  // ---------------------------------------------------------------------------
  logic             tbl_mode [DEPTH];
  logic [CLOG2T:0]  tbl_tile [DEPTH];
  logic [CNT_W-1:0] tbl_ifm  [DEPTH];
  logic [CNT_W-1:0] tbl_ofm  [DEPTH];

  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      tbl_mode[cfg_addr] <= cfg_mode;
      tbl_tile[cfg_addr] <= cfg_nb_tile;
      tbl_ifm[cfg_addr]  <= cfg_nb_ifmaps;
      tbl_ofm[cfg_addr]  <= cfg_nb_ofmaps;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer registers
  // ---------------------------------------------------------------------------
  logic [CLOG2L-1:0] layer;     // table entry currently being walked
  logic [CLOG2L:0]   nl_lat;    // saturated layer count for this sequence
  logic [CNT_W-1:0]  ofm_last;  // loop bounds held as "last index" values
  logic [CLOG2T-1:0] t_last;
  logic [CNT_W-1:0]  ifm_last;

  assign step_layer = layer;

  // ---------------------------------------------------------------------------
  // Loop bounds of the entry addressed by 'layer', as last-index values.
  // Zero counts behave as one; the FC ceilings are written as (n-1)/d so
  // the arithmetic never needs a wider intermediate.
  // ---------------------------------------------------------------------------
  logic             cur_mode;
  logic [CNT_W-1:0] ifm_fix;
  logic [CNT_W-1:0] ofm_fix;
  logic [CNT_W-1:0] ifm_last_c;
  logic [CNT_W-1:0] ofm_last_c;
  logic [CLOG2T-1:0] t_last_c;

  always_comb begin
    cur_mode   = tbl_mode[layer];
    ifm_fix    = (tbl_ifm[layer] == '0) ? ONE_C : tbl_ifm[layer];
    ofm_fix    = (tbl_ofm[layer] == '0) ? ONE_C : tbl_ofm[layer];
    ifm_last_c = '0;
    ofm_last_c = '0;
    t_last_c   = '0;
    if (cur_mode) begin
      ifm_last_c = (ifm_fix - ONE_C) / W_V;
      ofm_last_c = (ofm_fix - ONE_C) / WW_V;
      t_last_c   = '0;
    end else begin
      ifm_last_c = ifm_fix - ONE_C;
      ofm_last_c = ofm_fix - ONE_C;
      if (tbl_tile[layer] == '0) begin
        t_last_c = '0;
      end else if (tbl_tile[layer] > MAXT_V) begin
        t_last_c = '1;
      end else begin
        t_last_c = CLOG2T'(tbl_tile[layer] - ONE_T);
      end
    end
  end

  // Saturated layer count presented with start.
  logic [CLOG2L:0] nl_sat;
  assign nl_sat = (nb_layers > MAXL_V) ? MAXL_V : nb_layers;

  // Wrap conditions of each loop level at the current step.
  logic end_ifm;
  logic end_tcol;
  logic end_trow;
  logic end_ofm;
  logic more_layers;
  logic [CNT_W-1:0] ifm_inc;

  assign end_ifm     = (step_ifm == ifm_last);
  assign end_tcol    = (step_tcol == t_last);
  assign end_trow    = (step_trow == t_last);
  assign end_ofm     = (step_ofm == ofm_last);
  assign more_layers = (({1'b0, layer} + ONE_L) < nl_lat);
  assign ifm_inc     = step_ifm + ONE_C;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_valid <= 1'b0;
      layer      <= '0;
      nl_lat     <= '0;
      ofm_last   <= '0;
      t_last     <= '0;
      ifm_last   <= '0;
      step_mode  <= 1'b0;
      step_ofm   <= '0;
      step_trow  <= '0;
      step_tcol  <= '0;
      step_ifm   <= '0;
      step_first <= 1'b0;
      step_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            layer  <= '0;
            nl_lat <= nl_sat;
            if (nl_sat == '0) begin
              // Nothing to run: report completion straight away.
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SETUP;
              busy  <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          // 'layer' already points at the entry to run, so the comb bounds
          // are those of this layer.
          ofm_last   <= ofm_last_c;
          t_last     <= t_last_c;
          ifm_last   <= ifm_last_c;
          step_mode  <= cur_mode;
          step_ofm   <= '0;
          step_trow  <= '0;
          step_tcol  <= '0;
          step_ifm   <= '0;
          step_first <= 1'b1;
          step_last  <= (ifm_last_c == '0);
          step_valid <= 1'b1;
          state      <= S_RUN;
        end

        S_RUN: begin
          if (step_valid && step_ready) begin
            if (!end_ifm) begin
              step_ifm   <= ifm_inc;
              step_first <= 1'b0;
              step_last  <= (ifm_inc == ifm_last);
            end else begin
              step_ifm   <= '0;
              step_first <= 1'b1;
              step_last  <= (ifm_last == '0);
              if (!end_tcol) begin
                step_tcol <= step_tcol + 1'b1;
              end else begin
                step_tcol <= '0;
                if (!end_trow) begin
                  step_trow <= step_trow + 1'b1;
                end else begin
                  step_trow <= '0;
                  if (!end_ofm) begin
                    step_ofm <= step_ofm + ONE_C;
                  end else begin
                    // Final step of this layer has been accepted.
                    step_ofm   <= '0;
                    step_valid <= 1'b0;
                    if (more_layers) begin
                      layer <= layer + 1'b1;
                      state <= S_SETUP;
                    end else begin
                      state <= S_DONE;
                      busy  <= 1'b0;
                      done  <= 1'b1;
                    end
                  end
                end
              end
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          step_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_npu_layer_seq
//
// Drives descriptor tables and sequence starts into npu_layer_seq and checks
// the step stream against a loop-nest reference model built from the layer
// counts. It also checks the following:
//   - start and done timing
//   - hold behaviour under random backpressure
//   - ignored writes and starts while busy
//   - abort on reset
// -----------------------------------------------------------------------------
module tb_npu_layer_seq;

  localparam int W      = 8;
  localparam int CLOG2T = 2;
  localparam int CNT_W  = 10;
  localparam int CLOG2L = 3;
  localparam int REC_W  = CLOG2L + 1 + CNT_W + 2*CLOG2T + CNT_W + 2;
  localparam int MAX_CYC = 20000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              cfg_we;
  logic [CLOG2L-1:0] cfg_addr;
  logic              cfg_mode;
  logic [CLOG2T:0]   cfg_nb_tile;
  logic [CNT_W-1:0]  cfg_nb_ifmaps;
  logic [CNT_W-1:0]  cfg_nb_ofmaps;
  logic [CLOG2L:0]   nb_layers;
  logic              start;
  logic              busy;
  logic              done;
  logic              step_valid;
  logic              step_ready;
  logic [CLOG2L-1:0] step_layer;
  logic              step_mode;
  logic [CNT_W-1:0]  step_ofm;
  logic [CLOG2T-1:0] step_trow;
  logic [CLOG2T-1:0] step_tcol;
  logic [CNT_W-1:0]  step_ifm;
  logic              step_first;
  logic              step_last;

  npu_layer_seq #(.W(W), .CLOG2T(CLOG2T), .CNT_W(CNT_W), .CLOG2L(CLOG2L)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_nb_tile(cfg_nb_tile), .cfg_nb_ifmaps(cfg_nb_ifmaps),
    .cfg_nb_ofmaps(cfg_nb_ofmaps), .nb_layers(nb_layers), .start(start),
    .busy(busy), .done(done), .step_valid(step_valid), .step_ready(step_ready),
    .step_layer(step_layer), .step_mode(step_mode), .step_ofm(step_ofm),
    .step_trow(step_trow), .step_tcol(step_tcol), .step_ifm(step_ifm),
    .step_first(step_first), .step_last(step_last)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [REC_W-1:0] exp_q[$];
  int exp_layers;

  // Host-side copy of the descriptor table.
  int d_mode [8];
  int d_tile [8];
  int d_ifm  [8];
  int d_ofm  [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] obs();
    return {step_layer, step_mode, step_ofm, step_trow, step_tcol, step_ifm,
            step_first, step_last};
  endfunction

  // Reference model: the plain loop nest over each layer's effective counts.
  function automatic void build_exp(input int nl);
    int eff;
    int o, i, t, n_o, n_i, n_t;
    eff = (nl > 8) ? 8 : nl;
    exp_layers = eff;
    exp_q.delete();
    for (int l = 0; l < eff; l++) begin
      o = (d_ofm[l] == 0) ? 1 : d_ofm[l];
      i = (d_ifm[l] == 0) ? 1 : d_ifm[l];
      t = (d_tile[l] == 0) ? 1 : d_tile[l];
      if (t > 4) t = 4;
      if (d_mode[l] != 0) begin
        n_o = (o + W*W - 1) / (W*W);
        n_i = (i + W - 1) / W;
        n_t = 1;
      end else begin
        n_o = o;
        n_i = i;
        n_t = t;
      end
      for (int a = 0; a < n_o; a++)
        for (int r = 0; r < n_t; r++)
          for (int c = 0; c < n_t; c++)
            for (int f = 0; f < n_i; f++)
              exp_q.push_back({3'(l), 1'(d_mode[l]), 10'(a), 2'(r), 2'(c), 10'(f),
                               1'(f == 0), 1'(f == n_i - 1)});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_desc(input int slot, input int mode, input int tile,
                            input int ifm, input int ofm);
    @(negedge clk);
    cfg_we        = 1'b1;
    cfg_addr      = 3'(slot);
    cfg_mode      = 1'(mode);
    cfg_nb_tile   = 3'(tile);
    cfg_nb_ifmaps = 10'(ifm);
    cfg_nb_ofmaps = 10'(ofm);
    d_mode[slot] = mode;
    d_tile[slot] = tile;
    d_ifm[slot]  = ifm;
    d_ofm[slot]  = ofm;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Runs one sequence. ready_pct = chance of step_ready per cycle (100 = always).
  // poke: try a descriptor write and a second start while busy.
  // abort_at: assert rst once this many steps have been offered (0 = never).
  task automatic run_seq(input int nl, input int ready_pct, input bit poke,
                         input int abort_at);
    int cyc, hs, done_cyc, last_hs, first_valid, setup_cnt, done_cnt, total, busy_cnt;
    logic [REC_W-1:0] cur, prev, e;
    bit stall, finished, aborted;
    build_exp(nl);
    total = exp_q.size();
    hs = 0; done_cyc = 0; last_hs = 0; first_valid = 0; setup_cnt = 0;
    done_cnt = 0; busy_cnt = 0; stall = 0; finished = 0; aborted = 0; prev = '0;
    @(negedge clk);
    nb_layers = 4'(nl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < MAX_CYC) begin
      step_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      cur = obs();
      if (stall) begin
        check("hold_valid", {63'd0, step_valid}, 64'd1);
        check("hold_step", 64'(cur), 64'(prev));
      end
      if (busy && !step_valid) setup_cnt++;
      if (step_valid && first_valid == 0) first_valid = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1;
        check("done_busy", {63'd0, busy}, 64'd0);
        check("done_valid", {63'd0, step_valid}, 64'd0);
      end
      if (step_valid && step_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("step", 64'(cur), 64'(e));
        end
        hs++;
        last_hs = cyc;
      end
      stall = step_valid && !step_ready;
      prev  = cur;
      cfg_we = poke && (cyc == 5);
      if (cfg_we) begin
        cfg_addr = 3'd1; cfg_mode = 1'b0; cfg_nb_tile = 3'd4;
        cfg_nb_ifmaps = 10'd9; cfg_nb_ofmaps = 10'd9;
      end
      start = poke && (cyc == 3);
      if (abort_at > 0 && hs == abort_at) begin
        rst = 1'b1;
        aborted = 1;
        finished = 1;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    cfg_we = 1'b0;
    start  = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      check("abort_valid", {63'd0, step_valid}, 64'd0);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_idx", 64'(obs()), 64'd0);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_idle", 64'(busy_cnt), 64'd0);
      exp_q.delete();
    end else begin
      check("done_seen", 64'(done_cnt), 64'd1);
      check("handshakes", 64'(hs), 64'(total));
      check("left_over", 64'(exp_q.size()), 64'd0);
      check("setup_cycles", 64'(setup_cnt), 64'(exp_layers));
      if (exp_layers > 0) check("first_valid", 64'(first_valid), 64'd2);
      if (ready_pct >= 100)
        check("done_cyc", 64'(done_cyc), 64'(1 + total + exp_layers));
      else if (total > 0)
        check("done_cyc", 64'(done_cyc), 64'(last_hs + 1));
      @(negedge clk);
      check("done_pulse", {63'd0, done}, 64'd0);
      check("idle_busy", {63'd0, busy}, 64'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_mode = 1'b0; cfg_nb_tile = '0;
    cfg_nb_ifmaps = '0; cfg_nb_ofmaps = '0; nb_layers = '0; start = 1'b0;
    step_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, step_valid}, 64'd0);
    check("rst_step", 64'(obs()), 64'd0);
    rst = 1'b0;

    // C1 alone, always ready
    write_desc(0, 0, 4, 1, 6);
    run_seq(1, 100, 0, 0);

    // C1 then C2
    write_desc(1, 0, 2, 6, 16);
    run_seq(2, 100, 0, 0);

    // FC 120 -> 84
    write_desc(0, 1, 3, 120, 84);
    run_seq(1, 100, 0, 0);

    // C2 under random backpressure
    write_desc(0, 0, 2, 6, 16);
    run_seq(1, 50, 0, 0);

    // all-zero fields
    write_desc(0, 0, 0, 0, 0);
    run_seq(1, 100, 0, 0);

    // empty sequence
    run_seq(0, 100, 0, 0);

    // writes and start while busy are ignored
    write_desc(0, 0, 4, 1, 6);
    write_desc(1, 1, 3, 120, 84);
    run_seq(2, 70, 1, 0);

    // reset in the middle of C1
    write_desc(0, 0, 4, 1, 6);
    run_seq(1, 100, 0, 50);

    // random tables, random layer counts (including above the table depth)
    for (int r = 0; r < 5; r++) begin
      for (int s = 0; s < 8; s++) begin
        if ($urandom_range(0, 2) == 0)
          write_desc(s, 1, $urandom_range(0, 7), $urandom_range(0, 100),
                     $urandom_range(0, 200));
        else
          write_desc(s, 0, $urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 3));
      end
      run_seq($urandom_range(0, 15), $urandom_range(30, 100), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
